// File: rtl/alu_rs_pkg.sv
// rtl/alu_rs_pkg.sv - shared types and sizing for the ALU reservation station
//
// Purpose : ALU op codes, issue-buffer entry layout and age width.
//           The entry struct is sized by the RS_* constants below; the
//           station's BITWIDTH/NENTRIES/TAGWIDTH parameters default to them
//           and must stay equal to them.
// Ports   : none (package)
package alu_rs_pkg;

  localparam int RS_BITWIDTH = 32;
  localparam int RS_NENTRIES = 4;
  localparam int RS_TAGWIDTH = 4;
  localparam int AGEW        = $clog2(RS_NENTRIES);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SRA = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SRL = 3'd6,
    ALU_XOR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic                   valid;
    alu_op_e                op;
    logic                   a_rdy;
    logic [RS_BITWIDTH-1:0] a_val;
    logic [RS_TAGWIDTH-1:0] a_tag;
    logic                   b_rdy;
    logic [RS_BITWIDTH-1:0] b_val;
    logic [RS_TAGWIDTH-1:0] b_tag;
    logic [RS_TAGWIDTH-1:0] dst_tag;
    logic [AGEW-1:0]        age;
  } rs_entry_t;

endpackage

// File: rtl/rs_oldest_select.sv
// rtl/rs_oldest_select.sv - picks the oldest (smallest age) candidate entry
//
// Purpose : combinational age-based select over the issue buffer.
// Ports   : cand_i        candidate vector (valid && both operands ready)
//           ages_i        packed ages, entry i at [i*AGEW +: AGEW]
//           grant_o       one-hot grant of the oldest candidate
//           grant_valid_o at least one candidate present
module rs_oldest_select #(
  parameter int N    = 4,
  parameter int AGEW = 2
) (
  input  logic [N-1:0]      cand_i,
  input  logic [N*AGEW-1:0] ages_i,
  output logic [N-1:0]      grant_o,
  output logic              grant_valid_o
);

  logic [N-1:0]    grant;
  logic            found;
  logic [AGEW-1:0] best_age;

  // Ages of valid entries are unique, so a strict compare yields one winner.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_i[i] && (!found || (ages_i[i*AGEW +: AGEW] < best_age))) begin
        grant    = '0;
        grant[i] = 1'b1;
        best_age = ages_i[i*AGEW +: AGEW];
        found    = 1'b1;
      end
    end
  end

  assign grant_o       = grant;
  assign grant_valid_o = found;

endmodule

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - issue buffer in front of the integer ALU
//
// Purpose : holds up to NENTRIES dispatched ops, captures missing operands
//           from the CDB by tag, and moves the oldest fully-ready entry into
//           a registered A/B/ALUControl/dst_tag bundle for the ALU.
// Config  : ALU_RS_BYPASS_EN - a fully-ready dispatch that finds no buffered
//           candidate and a free output register goes straight to the output
//           register (latency 1) without allocating an entry.
// Ports   : clk, rst (sync, active-high), flush (squash everything)
//           disp_*  dispatch request/operands/tags, disp_ready back-pressure
//           cdb_*   result broadcast used for operand wakeup
//           out_*   issue register (out_valid doubles as ALU en), out_ready in
module alu_reservation_station
  import alu_rs_pkg::*;
#(
  parameter int BITWIDTH = RS_BITWIDTH,
  parameter int NENTRIES = RS_NENTRIES,
  parameter int TAGWIDTH = RS_TAGWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [2:0]          disp_op,
  input  logic                disp_a_rdy,
  input  logic [BITWIDTH-1:0] disp_a_val,
  input  logic [TAGWIDTH-1:0] disp_a_tag,
  input  logic                disp_b_rdy,
  input  logic [BITWIDTH-1:0] disp_b_val,
  input  logic [TAGWIDTH-1:0] disp_b_tag,
  input  logic [TAGWIDTH-1:0] disp_dst_tag,
  input  logic                cdb_valid,
  input  logic [TAGWIDTH-1:0] cdb_tag,
  input  logic [BITWIDTH-1:0] cdb_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_a,
  output logic [BITWIDTH-1:0] out_b,
  output logic [2:0]          out_ctrl,
  output logic [TAGWIDTH-1:0] out_dst_tag
);

  localparam logic [AGEW:0] FULL_CNT = NENTRIES[AGEW:0];

  rs_entry_t ent_q [NENTRIES];
  rs_entry_t ent_d [NENTRIES];

  logic                out_valid_q, out_valid_d;
  logic [BITWIDTH-1:0] out_a_q, out_a_d;
  logic [BITWIDTH-1:0] out_b_q, out_b_d;
  logic [2:0]          out_ctrl_q, out_ctrl_d;
  logic [TAGWIDTH-1:0] out_dst_q, out_dst_d;

  logic [AGEW:0]        count;
  logic [NENTRIES-1:0]  cand;
  logic [NENTRIES*AGEW-1:0] ages;
  logic [NENTRIES-1:0]  grant;
  logic                 grant_valid;
  logic [AGEW-1:0]      alloc_idx;
  logic                 free_found;
  rs_entry_t            new_ent;
  rs_entry_t            issue_ent;
  logic                 disp_a_hit, disp_b_hit;
  logic                 disp_fire, out_free, issue, bypass, alloc;

  // Occupancy, candidates and packed ages all come from registered state only.
  always_comb begin
    count      = '0;
    cand       = '0;
    ages       = '0;
    alloc_idx  = '0;
    free_found = 1'b0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (ent_q[i].valid) count = count + (AGEW+1)'(1);
      cand[i] = ent_q[i].valid && ent_q[i].a_rdy && ent_q[i].b_rdy;
      ages[i*AGEW +: AGEW] = ent_q[i].age;
      if (!ent_q[i].valid && !free_found) begin
        alloc_idx  = AGEW'(i);
        free_found = 1'b1;
      end
    end
  end

  rs_oldest_select #(
    .N    (NENTRIES),
    .AGEW (AGEW)
  ) u_select (
    .cand_i        (cand),
    .ages_i        (ages),
    .grant_o       (grant),
    .grant_valid_o (grant_valid)
  );

  always_comb begin
    issue_ent = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      if (grant[i]) issue_ent = ent_q[i];
    end
  end

  assign disp_ready = (count < FULL_CNT);
  assign disp_fire  = disp_valid && disp_ready;
  assign out_free   = !out_valid_q || out_ready;
  assign issue      = grant_valid && out_free;

  // Dispatch sees the CDB of its own cycle so a same-cycle broadcast is not lost.
  assign disp_a_hit = cdb_valid && !disp_a_rdy && (disp_a_tag == cdb_tag);
  assign disp_b_hit = cdb_valid && !disp_b_rdy && (disp_b_tag == cdb_tag);

  always_comb begin
    new_ent         = '0;
    new_ent.valid   = 1'b1;
    new_ent.op      = alu_op_e'(disp_op);
    new_ent.a_rdy   = disp_a_rdy || disp_a_hit;
    new_ent.a_val   = disp_a_hit ? cdb_data : disp_a_val;
    new_ent.a_tag   = disp_a_tag;
    new_ent.b_rdy   = disp_b_rdy || disp_b_hit;
    new_ent.b_val   = disp_b_hit ? cdb_data : disp_b_val;
    new_ent.b_tag   = disp_b_tag;
    new_ent.dst_tag = disp_dst_tag;
    new_ent.age     = count[AGEW-1:0];
  end

`ifdef ALU_RS_BYPASS_EN
  assign bypass = disp_fire && new_ent.a_rdy && new_ent.b_rdy && !grant_valid && out_free;
`else
  assign bypass = 1'b0;
`endif
  assign alloc = disp_fire && !bypass;

  // Entry next state: wakeup, free on issue, allocate, then age compaction.
  // The new entry takes age=count and is also compacted, so it lands one
  // above the youngest survivor when an issue happens in the same cycle.
  always_comb begin
    for (int i = 0; i < NENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && cdb_valid) begin
        if (!ent_q[i].a_rdy && (ent_q[i].a_tag == cdb_tag)) begin
          ent_d[i].a_rdy = 1'b1;
          ent_d[i].a_val = cdb_data;
        end
        if (!ent_q[i].b_rdy && (ent_q[i].b_tag == cdb_tag)) begin
          ent_d[i].b_rdy = 1'b1;
          ent_d[i].b_val = cdb_data;
        end
      end
      if (issue && grant[i]) ent_d[i].valid = 1'b0;
      if (alloc && (alloc_idx == AGEW'(i))) ent_d[i] = new_ent;
      if (issue && ent_d[i].valid && (ent_d[i].age > issue_ent.age)) begin
        ent_d[i].age = ent_d[i].age - AGEW'(1);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_ctrl_d  = out_ctrl_q;
    out_dst_d   = out_dst_q;
    if (issue) begin
      out_valid_d = 1'b1;
      out_a_d     = issue_ent.a_val;
      out_b_d     = issue_ent.b_val;
      out_ctrl_d  = issue_ent.op;
      out_dst_d   = issue_ent.dst_tag;
    end else if (bypass) begin
      out_valid_d = 1'b1;
      out_a_d     = new_ent.a_val;
      out_b_d     = new_ent.b_val;
      out_ctrl_d  = new_ent.op;
      out_dst_d   = new_ent.dst_tag;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NENTRIES; i++) ent_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_ctrl_q  <= '0;
      out_dst_q   <= '0;
    end else begin
      for (int i = 0; i < NENTRIES; i++) ent_q[i] <= ent_d[i];
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_ctrl_q  <= out_ctrl_d;
      out_dst_q   <= out_dst_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_dst_tag = out_dst_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - directed self-checking bench for alu_reservation_station
module tb_alu_reservation_station;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        disp_valid, disp_ready;
  logic [2:0]  disp_op;
  logic        disp_a_rdy, disp_b_rdy;
  logic [31:0] disp_a_val, disp_b_val;
  logic [3:0]  disp_a_tag, disp_b_tag, disp_dst_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_ctrl;
  logic [3:0]  out_dst_tag;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_reservation_station dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .disp_valid   (disp_valid),
    .disp_ready   (disp_ready),
    .disp_op      (disp_op),
    .disp_a_rdy   (disp_a_rdy),
    .disp_a_val   (disp_a_val),
    .disp_a_tag   (disp_a_tag),
    .disp_b_rdy   (disp_b_rdy),
    .disp_b_val   (disp_b_val),
    .disp_b_tag   (disp_b_tag),
    .disp_dst_tag (disp_dst_tag),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_ctrl     (out_ctrl),
    .out_dst_tag  (out_dst_tag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One dispatch beat: present the op for one edge, then drop disp_valid.
  task automatic disp(input logic [2:0] op, input logic a_rdy, input logic [31:0] a_val,
                      input logic [3:0] a_tag, input logic b_rdy, input logic [31:0] b_val,
                      input logic [3:0] b_tag, input logic [3:0] dst);
    disp_valid   = 1'b1;
    disp_op      = op;
    disp_a_rdy   = a_rdy;
    disp_a_val   = a_val;
    disp_a_tag   = a_tag;
    disp_b_rdy   = b_rdy;
    disp_b_val   = b_val;
    disp_b_tag   = b_tag;
    disp_dst_tag = dst;
    tick();
    disp_valid   = 1'b0;
  endtask

  task automatic bcast(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
    tick();
    cdb_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] ctrl, input logic [3:0] dst);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_a"}, out_a, a);
    check({tag, "_b"}, out_b, b);
    check({tag, "_ctrl"}, out_ctrl, ctrl);
    check({tag, "_dst"}, out_dst_tag, dst);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_op = 3'd0;
    disp_a_rdy = 1'b0; disp_a_val = '0; disp_a_tag = '0;
    disp_b_rdy = 1'b0; disp_b_val = '0; disp_b_tag = '0; disp_dst_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; out_ready = 1'b1;

    // Reset
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    check("rst_out_dst", out_dst_tag, 0);
    rst = 1'b0;

    // Ready dispatch latency
    disp(3'd0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3);
`ifndef ALU_RS_BYPASS_EN
    check("lat_not_early", out_valid, 0);
    tick();
`endif
    check_out("lat", 32'd5, 32'd7, 3'd0, 4'd3);
    tick();
    check("lat_drain", out_valid, 0);

    // Late CDB wakeup
    disp(3'd1, 1'b1, 32'd10, 4'd0, 1'b0, 32'd0, 4'd9, 4'd5);
    tick();
    check("wake_wait", out_valid, 0);
    bcast(4'd9, 32'd4);
    check("wake_not_same_edge", out_valid, 0);
    tick();
    check_out("wake", 32'd10, 32'd4, 3'd1, 4'd5);
    tick();
    check("wake_drain", out_valid, 0);

    // CDB in the dispatch cycle
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd6;
    disp(3'd1, 1'b1, 32'd10, 4'd0, 1'b0, 32'd0, 4'd9, 4'd6);
    cdb_valid = 1'b0;
`ifndef ALU_RS_BYPASS_EN
    check("same_cyc_not_early", out_valid, 0);
    tick();
`endif
    check_out("same_cyc", 32'd10, 32'd6, 3'd1, 4'd6);
    tick();
    check("same_cyc_drain", out_valid, 0);

    // Fill, then wake out of order; age decides among simultaneous candidates
    for (int i = 0; i < 4; i++)
      disp(3'd7, 1'b1, 32'd100 + i, 4'd0, 1'b0, 32'd0, 4'(i + 1), 4'(i + 1));
    check("full_disp_ready", disp_ready, 0);
    out_ready = 1'b0;
    bcast(4'd4, 32'd40);
    check("age_wake4_wait", out_valid, 0);
    tick();
    check_out("age_first", 32'd103, 32'd40, 3'd7, 4'd4);
    check("age_slot_freed", disp_ready, 1);
    bcast(4'd2, 32'd20);
    bcast(4'd3, 32'd30);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", out_valid, 1);
      check("stall_dst", out_dst_tag, 4);
      check("stall_b", out_b, 40);
    end
    out_ready = 1'b1;
    tick();
    check_out("b2b_1", 32'd101, 32'd20, 3'd7, 4'd2);
    tick();
    check_out("b2b_2", 32'd102, 32'd30, 3'd7, 4'd3);
    tick();
    check("b2b_empty", out_valid, 0);
    bcast(4'd1, 32'd10);
    tick();
    check_out("last", 32'd100, 32'd10, 3'd7, 4'd1);
    tick();
    check("last_drain", out_valid, 0);

    // Flush while full with a stalled output
    out_ready = 1'b0;
    disp(3'd2, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd10);
    disp(3'd3, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd11);
    disp(3'd4, 1'b0, 32'd0, 4'd12, 1'b1, 32'd5, 4'd0, 4'd12);
    disp(3'd5, 1'b0, 32'd0, 4'd13, 1'b1, 32'd6, 4'd0, 4'd13);
    disp(3'd6, 1'b0, 32'd0, 4'd14, 1'b1, 32'd7, 4'd0, 4'd14);
    check("pre_flush_full", disp_ready, 0);
    check("pre_flush_valid", out_valid, 1);
    check("pre_flush_dst", out_dst_tag, 10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_disp_ready", disp_ready, 1);
    check("flush_out_a", out_a, 0);
    out_ready = 1'b1;
    bcast(4'd12, 32'd1);
    bcast(4'd13, 32'd2);
    bcast(4'd14, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_issue", out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
